// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - RR/EX to multiply/divide unit bundle with HI/LO and MF* return path
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            valid_ex;
  logic            flush_ex;
  logic [5:0]      opcode_ex;
  logic [5:0]      funct_ex;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            stall;
  logic            busy;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] mf_data;
  logic            mf_valid;

  modport master (
    output valid_ex, flush_ex, opcode_ex, funct_ex, rs_val, rt_val,
    input  stall, busy, hi, lo, mf_data, mf_valid
  );

  modport slave (
    input  valid_ex, flush_ex, opcode_ex, funct_ex, rs_val, rt_val,
    output stall, busy, hi, lo, mf_data, mf_valid
  );
endinterface

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative MULT/DIV unit with private HI/LO; divider compiled in by MULDIV_DIV_EN
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic       clk,
  input  logic       rst,
  ex_muldiv_if.slave ex
);
  localparam int            CW      = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] LAST    = CW'(ITERS - 1);
  localparam logic [5:0]    F_MFHI  = 6'h10;
  localparam logic [5:0]    F_MTHI  = 6'h11;
  localparam logic [5:0]    F_MFLO  = 6'h12;
  localparam logic [5:0]    F_MTLO  = 6'h13;
  localparam logic [5:0]    F_MULT  = 6'h18;
  localparam logic [5:0]    F_MULTU = 6'h19;
`ifdef MULDIV_DIV_EN
  localparam logic [5:0]    F_DIV   = 6'h1A;
  localparam logic [5:0]    F_DIVU  = 6'h1B;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;       // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   opnd;      // |rs| for multiply, |rt| for divide
  logic [XLEN-1:0]   hi_q, lo_q;
  logic              neg_main;  // negate product or quotient
`ifdef MULDIV_DIV_EN
  logic              op_div, neg_rem, div_zero;
  logic [XLEN-1:0]   dividend_raw;
  logic [XLEN:0]     div_shift, div_diff;
`endif

  logic              r_type, is_mf, is_mt, is_mul, is_div, live, busy, accept;
  logic              signed_op, rs_neg, rt_neg;
  logic [XLEN-1:0]   rs_mag, rt_mag;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] step, prod_fix;
  logic [XLEN-1:0]   hi_fix, lo_fix;

  assign busy = (state != S_IDLE);

  // Instruction decode, acceptance and operand magnitudes
  always_comb begin
    r_type = (ex.opcode_ex == 6'h00);
    is_mf  = (ex.funct_ex == F_MFHI) || (ex.funct_ex == F_MFLO);
    is_mt  = (ex.funct_ex == F_MTHI) || (ex.funct_ex == F_MTLO);
    is_mul = (ex.funct_ex == F_MULT) || (ex.funct_ex == F_MULTU);
`ifdef MULDIV_DIV_EN
    is_div = (ex.funct_ex == F_DIV) || (ex.funct_ex == F_DIVU);
`else
    is_div = 1'b0;
`endif
    live      = ex.valid_ex & ~ex.flush_ex & r_type & (is_mf | is_mt | is_mul | is_div);
    accept    = live & ~busy & (is_mul | is_div);
    signed_op = ~ex.funct_ex[0];
    rs_neg    = signed_op & ex.rs_val[XLEN-1];
    rt_neg    = signed_op & ex.rt_val[XLEN-1];
    rs_mag    = rs_neg ? -ex.rs_val : ex.rs_val;
    rt_mag    = rt_neg ? -ex.rt_val : ex.rt_val;
  end

  assign ex.busy     = busy;
  assign ex.stall    = live & busy;
  assign ex.hi       = hi_q;
  assign ex.lo       = lo_q;
  assign ex.mf_valid = live & ~busy & is_mf;
  assign ex.mf_data  = (live & ~busy & is_mf) ? ((ex.funct_ex == F_MFHI) ? hi_q : lo_q) : '0;

  // Next-state logic: one RUN pass per iteration, then a single FIX cycle
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (accept) state_nx = S_RUN;
      S_RUN:   if (cnt == LAST) state_nx = S_FIX;
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // One shift-add (multiply) or restoring-subtract (divide) iteration
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
    step    = acc[0] ? {mul_sum, acc[XLEN-1:1]}
                     : {1'b0, acc[2*XLEN-1:XLEN], acc[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (op_div) begin
      step = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                            : {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
    end
`endif
  end

  // Sign correction and special-case results written in FIX
  always_comb begin
    prod_fix = neg_main ? -acc : acc;
    hi_fix   = prod_fix[2*XLEN-1:XLEN];
    lo_fix   = prod_fix[XLEN-1:0];
`ifdef MULDIV_DIV_EN
    if (op_div) begin
      if (div_zero) begin
        hi_fix = dividend_raw;
        lo_fix = '1;
      end else begin
        lo_fix = neg_main ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        hi_fix = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      end
    end
`endif
  end

  // State, datapath and HI/LO registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      acc          <= '0;
      opnd         <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      neg_main     <= 1'b0;
`ifdef MULDIV_DIV_EN
      op_div       <= 1'b0;
      neg_rem      <= 1'b0;
      div_zero     <= 1'b0;
      dividend_raw <= '0;
`endif
    end else begin
      state <= state_nx;
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (accept) begin
            neg_main <= rs_neg ^ rt_neg;
`ifdef MULDIV_DIV_EN
            op_div       <= is_div;
            neg_rem      <= rs_neg;
            div_zero     <= (ex.rt_val == '0);
            dividend_raw <= ex.rs_val;
            if (is_div) begin
              acc  <= {{XLEN{1'b0}}, rs_mag};
              opnd <= rt_mag;
            end else
`endif
            begin
              acc  <= {{XLEN{1'b0}}, rt_mag};
              opnd <= rs_mag;
            end
          end else if (live & is_mt) begin
            if (ex.funct_ex == F_MTHI) hi_q <= ex.rs_val;
            else                       lo_q <= ex.rs_val;
          end
        end
        S_RUN: begin
          acc <= step;
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          hi_q <= hi_fix;
          lo_q <= lo_fix;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - self-checking bench for ex_muldiv: vector table, corner sequences, random vs model
module tb_ex_muldiv;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];
  logic [5:0] pool[$];

  ex_muldiv_if #(.XLEN(32)) bus();
  ex_muldiv #(.XLEN(32), .ITERS(32)) dut (.clk(clk), .rst(rst), .ex(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic fl, input logic [5:0] op,
                       input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.valid_ex  = v;
    bus.flush_ex  = fl;
    bus.opcode_ex = op;
    bus.funct_ex  = f;
    bus.rs_val    = a;
    bus.rt_val    = b;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
  endtask

  task automatic add_vec(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo, input string name);
    vec_t v;
    v.funct = f; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.name = name;
    vecs.push_back(v);
  endtask

  // Issue one mul/div, return the number of busy cycles seen at negedges
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int bc);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 6'h00, f, a, b);
    @(posedge clk); #1;
    idle();
    bc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy) bc++;
      else break;
    end
  endtask

  task automatic mt(input logic [5:0] f, input logic [31:0] v);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 6'h00, f, v, 32'h0);
    @(posedge clk); #1;
    idle();
  endtask

  function automatic logic [63:0] ref_model(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb;
    int ia, ib, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      F_MULT:  return 64'(sa * sb);
      F_MULTU: return {32'h0, a} * {32'h0, b};
      F_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = ia / ib;
        r = ia % ib;
        return {32'(r), 32'(q)};
      end
      F_DIVU: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int bc, sc;
    logic [63:0] exp;
    logic [5:0]  f;
    logic [31:0] a, b;

    add_vec(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
    add_vec(F_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_m3x7");
    add_vec(F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minsq");
    add_vec(F_MULTU, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, "multu_zero");
    add_vec(F_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, "mult_maxxm1");
`ifdef MULDIV_DIV_EN
    add_vec(F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7by2");
    add_vec(F_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, "divu_by0");
    add_vec(F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf");
    add_vec(F_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_neg_by0");
    add_vec(F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7bym2");
    add_vec(F_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, "divu_max16");
`endif

    // Reset state
    rst = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_stall", 64'(bus.stall), 64'h0);
    check("rst_hi", 64'(bus.hi), 64'h0);
    check("rst_lo", 64'(bus.lo), 64'h0);
    check("rst_mf_valid", 64'(bus.mf_valid), 64'h0);
    check("rst_mf_data", 64'(bus.mf_data), 64'h0);
    rst = 1'b1;

    // Vector table
    foreach (vecs[i]) begin
      run_op(vecs[i].funct, vecs[i].a, vecs[i].b, bc);
      check({vecs[i].name, "_busy_cycles"}, 64'(bc), 64'd33);
      check({vecs[i].name, "_hi"}, 64'(bus.hi), 64'(vecs[i].hi));
      check({vecs[i].name, "_lo"}, 64'(bus.lo), 64'(vecs[i].lo));
    end

    // MTHI/MTLO while idle, then MFHI combinational read
    mt(F_MTHI, 32'hA5A5A5A5);
    check("mthi_hi", 64'(bus.hi), 64'hA5A5A5A5);
    mt(F_MTLO, 32'h5A5A0001);
    check("mtlo_lo", 64'(bus.lo), 64'h5A5A0001);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 6'h00, F_MFHI, 32'h0, 32'h0);
    #1;
    check("mfhi_valid", 64'(bus.mf_valid), 64'h1);
    check("mfhi_data", 64'(bus.mf_data), 64'hA5A5A5A5);
    check("mfhi_stall", 64'(bus.stall), 64'h0);
    idle();
    #1;
    check("mf_idle_valid", 64'(bus.mf_valid), 64'h0);
    check("mf_idle_data", 64'(bus.mf_data), 64'h0);

`ifndef MULDIV_DIV_EN
    // Divide compiled out: DIV is a no-op
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 6'h00, F_DIV, 32'd10, 32'd2);
    @(negedge clk);
    check("nodiv_stall", 64'(bus.stall), 64'h0);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check("nodiv_busy", 64'(bus.busy), 64'h0);
    check("nodiv_hi", 64'(bus.hi), 64'hA5A5A5A5);
    check("nodiv_lo", 64'(bus.lo), 64'h5A5A0001);
`endif

    // MFLO stalled behind a MULT
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 6'h00, F_MULT, 32'hFFFFFFFD, 32'd7);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 6'h00, F_MFLO, 32'h0, 32'h0);
    sc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.stall) sc++;
      else break;
    end
    check("mflo_stall_cycles", 64'(sc), 64'd33);
    check("mflo_valid", 64'(bus.mf_valid), 64'h1);
    check("mflo_data", 64'(bus.mf_data), 64'hFFFFFFEB);
    @(posedge clk); #1;
    idle();

    // Back-to-back multiplies: second one waits, then starts without a bubble
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 6'h00, F_MULT, 32'd5, 32'd6);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 6'h00, F_MULTU, 32'hFFFFFFFF, 32'd2);
    sc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.stall) sc++;
      else break;
    end
    check("b2b_stall_cycles", 64'(sc), 64'd33);
    check("b2b_first_lo", 64'(bus.lo), 64'd30);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check("b2b_second_busy", 64'(bus.busy), 64'h1);
    bc = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy) bc++;
      else break;
    end
    check("b2b_second_busy_cycles", 64'(bc), 64'd33);
    check("b2b_second_hilo", {bus.hi, bus.lo}, 64'h00000001_FFFFFFFE);

    // Flushed MULT and non-R-type opcode are not accepted
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 6'h00, F_MULT, 32'd3, 32'd3);
    @(negedge clk);
    check("flush_stall", 64'(bus.stall), 64'h0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 6'h01, F_MULT, 32'd3, 32'd3);
    @(negedge clk);
    check("flush_busy", 64'(bus.busy), 64'h0);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check("nonr_busy", 64'(bus.busy), 64'h0);
    check("flush_hilo", {bus.hi, bus.lo}, 64'h00000001_FFFFFFFE);

    // Asynchronous reset in the middle of RUN
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 6'h00, F_MULT, 32'd100, 32'd200);
    @(posedge clk); #1;
    idle();
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'h0);
    check("midrst_hilo", {bus.hi, bus.lo}, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    run_op(F_MULT, 32'd100, 32'd200, bc);
    check("postrst_busy_cycles", 64'(bc), 64'd33);
    check("postrst_hilo", {bus.hi, bus.lo}, 64'd20000);

    // Randomized operations against the reference model
    pool.push_back(F_MULT);
    pool.push_back(F_MULTU);
`ifdef MULDIV_DIV_EN
    pool.push_back(F_DIV);
    pool.push_back(F_DIVU);
`endif
    for (int i = 0; i < 60; i++) begin
      f = pool[$urandom_range(0, pool.size() - 1)];
      a = rand_opnd();
      b = rand_opnd();
      exp = ref_model(f, a, b);
      run_op(f, a, b, bc);
      check($sformatf("rand%0d_f%h_%h_%h_busy", i, f, a, b), 64'(bc), 64'd33);
      check($sformatf("rand%0d_f%h_%h_%h_hilo", i, f, a, b), {bus.hi, bus.lo}, exp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
